regfile_sb: RTL

Parametrised integer register file with a built-in scoreboard, replacing the fixed 2-read/1-write, 32×32 file in the core datapath. It provides NREAD combinational read ports and one write port. Per-register busy bits are set when the issue stage claims a destination and cleared on writeback. An optional write-to-read bypass is included. Decode uses the busy bits and the claim handshake to stall on RAW and WAW hazards.

---
 rtl/regfile_pkg.sv | 16 +
 rtl/regfile_scoreboard.sv | 75 +++++++
 rtl/regfile_sb.sv | 86 ++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the register file with integrated scoreboard.
// Holds the default sizing constants, the index of the hard-wired zero
// register and a register address type for the default configuration.
// No ports; imported by regfile_scoreboard and regfile_sb.
package regfile_pkg;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_NREGS = 32;
  localparam int DEF_NREAD = 2;

  // Register 0 is hard-wired to zero and is never tracked as busy.
  localparam int REG_ZERO = 0;

  typedef logic [$clog2(DEF_NREGS)-1:0] regAddr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard for the register file.
// Tracks which registers have an outstanding producer, decides whether a
// claim can be accepted this cycle and keeps a running count of busy
// registers.
// Ports:
//   clk, reset      clock and synchronous active-low reset
//   wrEn_i          writeback valid
//   wrAddr_i        writeback destination (clears its busy bit)
//   claimEn_i       issue stage requests ownership of claimAddr_i
//   claimAddr_i     destination being claimed
//   busy_o          per-register busy vector (bit 0 always 0)
//   claimReady_o    a claim this cycle would be accepted
//   busyCount_o     number of registers currently busy
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = DEF_NREGS,
  localparam int AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wrEn_i,
  input  logic [AW-1:0]    wrAddr_i,
  input  logic             claimEn_i,
  input  logic [AW-1:0]    claimAddr_i,
  output logic [NREGS-1:0] busy_o,
  output logic             claimReady_o,
  output logic [AW:0]      busyCount_o
);

  logic [NREGS-1:0] busy_q, busy_d;
  logic [NREGS-1:0] clearVec, setVec;
  logic [AW:0]      busyCount_q, busyCount_d;
  logic             wrLive, claimLive, claimReady, wrFreesBusy;

  // Next-state for the busy vector. The write clears first and the claim
  // sets afterwards, so a same-cycle write and claim to one register leaves
  // it busy on behalf of the newer producer. A claim can only be accepted
  // when its bit is currently free or is being freed by this write, so an
  // accepted claim always adds exactly one busy register.
  always_comb begin
    clearVec    = '0;
    setVec      = '0;
    wrLive      = wrEn_i && (wrAddr_i != AW'(REG_ZERO));
    claimReady  = (claimAddr_i == AW'(REG_ZERO)) || !busy_q[claimAddr_i] ||
                  (wrEn_i && (wrAddr_i == claimAddr_i));
    claimLive   = claimEn_i && claimReady && (claimAddr_i != AW'(REG_ZERO));
    wrFreesBusy = wrLive && busy_q[wrAddr_i];
    if (wrLive) begin
      clearVec[wrAddr_i] = 1'b1;
    end
    if (claimLive) begin
      setVec[claimAddr_i] = 1'b1;
    end
    busy_d           = (busy_q & ~clearVec) | setVec;
    busy_d[REG_ZERO] = 1'b0;
    busyCount_d      = busyCount_q + (AW+1)'(claimLive) - (AW+1)'(wrFreesBusy);
  end

  // Scoreboard state; reset overrides any same-cycle write or claim.
  always_ff @(posedge clk) begin
    if (!reset) begin
      busy_q      <= '0;
      busyCount_q <= '0;
    end else begin
      busy_q      <= busy_d;
      busyCount_q <= busyCount_d;
    end
  end

  assign busy_o       = busy_q;
  assign claimReady_o = claimReady;
  assign busyCount_o  = busyCount_q;

endmodule

// File: rtl/regfile_sb.sv
// Parametrised integer register file with built-in scoreboard.
// NREAD combinational read ports, one write port, per-register busy bits
// managed by regfile_scoreboard. Register 0 always reads zero.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write
// data to matching read ports (and report them not busy).
// Ports:
//   clk, reset    clock and synchronous active-low reset
//   rd_addr       packed read addresses, port i at [i*AW +: AW]
//   rd_data       packed read data, port i at [i*XLEN +: XLEN]
//   rd_busy       per-port busy flag of the addressed register
//   wr_en/wr_addr/wr_data   writeback port
//   claim_en/claim_addr     issue-stage destination claim
//   claim_ready   a claim this cycle would be accepted
//   busy_count    number of busy registers
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int NREGS = DEF_NREGS,
  parameter int NREAD = DEF_NREAD,
  localparam int AW = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*XLEN-1:0] rd_data,
  output logic [NREAD-1:0]      rd_busy,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [XLEN-1:0]       wr_data,
  input  logic                  claim_en,
  input  logic [AW-1:0]         claim_addr,
  output logic                  claim_ready,
  output logic [AW:0]           busy_count
);

  logic [XLEN-1:0]  regArray_q [NREGS];
  logic [NREGS-1:0] busyVec;

  regfile_scoreboard #(
    .NREGS (NREGS)
  ) u_scoreboard (
    .clk          (clk),
    .reset        (reset),
    .wrEn_i       (wr_en),
    .wrAddr_i     (wr_addr),
    .claimEn_i    (claim_en),
    .claimAddr_i  (claim_addr),
    .busy_o       (busyVec),
    .claimReady_o (claim_ready),
    .busyCount_o  (busy_count)
  );

  // Data array. Writes to register 0 are dropped so it stays zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int r = 0; r < NREGS; r++) begin
        regArray_q[r] <= '0;
      end
    end else if (wr_en && (wr_addr != AW'(REG_ZERO))) begin
      regArray_q[wr_addr] <= wr_data;
    end
  end

  // One read mux per port, optionally overridden by the writeback bypass.
  for (genvar p = 0; p < NREAD; p++) begin : g_read
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] arrayData;
    logic            arrayBusy;

    assign addr      = rd_addr[p*AW +: AW];
    assign arrayData = (addr == AW'(REG_ZERO)) ? '0 : regArray_q[addr];
    assign arrayBusy = busyVec[addr];

`ifdef REGFILE_BYPASS_EN
    logic fwd;
    assign fwd = wr_en && (wr_addr == addr) && (addr != AW'(REG_ZERO));
    assign rd_data[p*XLEN +: XLEN] = fwd ? wr_data : arrayData;
    assign rd_busy[p]              = fwd ? 1'b0 : arrayBusy;
`else
    assign rd_data[p*XLEN +: XLEN] = arrayData;
    assign rd_busy[p]              = arrayBusy;
`endif
  end

endmodule
